flappy_game_ctrl: RTL and testbench

// - Game sequencer for the one-row bird datapath on the LED display.
// - Generates the bird block's start (run enable), die (respawn) and up (flap) controls, plus a slow tick.
// - Detects collisions between the bird row and the pipe column, keeps the score and runs run/pause/death flow.
// - Sits between the debounced KEY inputs, the pipe generator and the bird movement datapath.

---
 rtl/flappy_game_ctrl_if.sv | 28 ++
 rtl/flappy_game_ctrl.sv | 126 ++++++++++++
 tb/tb_flappy_game_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/flappy_game_ctrl_if.sv
// Bundle between the flappy game sequencer and its neighbours (keys, pipe generator, bird datapath).
// The sequencer is the slave; whatever drives keys and pipe info is the master.
interface flappy_game_ctrl_if #(
  parameter int ROWS    = 16,
  parameter int SCORE_W = 4
);
  logic               start_key;
  logic               flap_key;
  logic [ROWS-1:0]    bird_row;
  logic [ROWS-1:0]    pipe_col;
  logic               pipe_pass;
  logic               start;
  logic               die;
  logic               up;
  logic               tick;
  logic [SCORE_W-1:0] score;
  logic [1:0]         state;

  modport slave (
    input  start_key, flap_key, bird_row, pipe_col, pipe_pass,
    output start, die, up, tick, score, state
  );

  modport master (
    output start_key, flap_key, bird_row, pipe_col, pipe_pass,
    input  start, die, up, tick, score, state
  );
endinterface

// File: rtl/flappy_game_ctrl.sv
// Game sequencer for the one-row bird: run/pause/death flow, collision, score and slow tick.
// All next-state values come from one always_comb; one always_ff holds every register.
module flappy_game_ctrl #(
  parameter int ROWS       = 16,
  parameter int TICK_W     = 10,
  parameter int DEAD_TICKS = 4,
  parameter int SCORE_W    = 4
) (
  input  logic                clock,
  input  logic                reset,
  flappy_game_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DEAD  = 2'b11
  } state_e;

  localparam int DCNT_W = (DEAD_TICKS < 2) ? 1 : $clog2(DEAD_TICKS);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
  localparam logic [DCNT_W-1:0]  DCNT_LAST  = DCNT_W'(DEAD_TICKS - 1);

  state_e              state_q, state_d;
  logic [TICK_W-1:0]   cnt_q, cnt_d;
  logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic                start_key_q, start_key_d;
  logic                start_q, start_d;
  logic                die_q, die_d;
  logic                up_q, up_d;

  logic [ROWS-1:0]     bird_row;
  logic [ROWS-1:0]     pipe_col;
  logic                start_press;
  logic                hit;
  logic                counting;
  logic                tick;

  assign bird_row    = bus.bird_row;
  assign pipe_col    = bus.pipe_col;
  assign start_press = bus.start_key & ~start_key_q;

  // Off the top (no row bit set) and the floor row both count as a crash.
  assign hit = (|(bird_row & pipe_col)) | (bird_row == '0) | bird_row[ROWS-1];

  assign counting = (state_q == S_RUN) || (state_q == S_DEAD);
  assign tick     = counting && (&cnt_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dcnt_d      = dcnt_q;
    score_d     = score_q;
    start_key_d = bus.start_key;
    die_d       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start_press) begin
          state_d = S_RUN;
          score_d = '0;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (hit) begin
          state_d = S_DEAD;
          die_d   = 1'b1;
          dcnt_d  = '0;
        end else if (start_press) begin
          state_d = S_PAUSE;
        end else if (bus.pipe_pass && (score_q != SCORE_MAX)) begin
          score_d = score_q + 1'b1;
        end
      end
      S_PAUSE: begin
        if (start_press) state_d = S_RUN;
      end
      S_DEAD: begin
        cnt_d = cnt_q + 1'b1;
        if (tick) begin
          if (dcnt_q == DCNT_LAST) state_d = S_IDLE;
          else                     dcnt_d  = dcnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Gate on the next state so start/up line up with the visible state.
    start_d = (state_d == S_RUN);
    up_d    = bus.flap_key && (state_d == S_RUN);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dcnt_q      <= '0;
      score_q     <= '0;
      start_key_q <= 1'b0;
      start_q     <= 1'b0;
      die_q       <= 1'b0;
      up_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dcnt_q      <= dcnt_d;
      score_q     <= score_d;
      start_key_q <= start_key_d;
      start_q     <= start_d;
      die_q       <= die_d;
      up_q        <= up_d;
    end
  end

  assign bus.start = start_q;
  assign bus.die   = die_q;
  assign bus.up    = up_q;
  assign bus.tick  = tick;
  assign bus.score = score_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Directed bench for flappy_game_ctrl with a short prescaler and 2-bit score.
module tb_flappy_game_ctrl;
  logic clock;
  logic reset;
  int   errors;
  int   checks;
  int   n;
  int   ticks;

  flappy_game_ctrl_if #(.ROWS(16), .SCORE_W(2)) bus ();

  flappy_game_ctrl #(
    .ROWS(16), .TICK_W(2), .DEAD_TICKS(2), .SCORE_W(2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [1:0] exp_score);
    bus.pipe_pass = 1'b1;
    cyc();
    bus.pipe_pass = 1'b0;
    chk("score_pulse", 16'(bus.score), 16'(exp_score));
    cyc();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    bus.start_key = 1'b0;
    bus.flap_key  = 1'b0;
    bus.bird_row  = 16'h0100;
    bus.pipe_col  = 16'h0000;
    bus.pipe_pass = 1'b0;

    // reset state
    repeat (3) cyc();
    chk("rst_state", 16'(bus.state), 16'h0);
    chk("rst_start", 16'(bus.start), 16'h0);
    chk("rst_die",   16'(bus.die),   16'h0);
    chk("rst_tick",  16'(bus.tick),  16'h0);
    chk("rst_score", 16'(bus.score), 16'h0);
    chk("rst_up",    16'(bus.up),    16'h0);
    reset = 1'b0;
    cyc();
    chk("idle_hold", 16'(bus.state), 16'h0);

    // game 1: held start_key enters RUN once, tick every 4 clocks
    bus.start_key = 1'b1;
    cyc(); chk("run_e1", 16'(bus.state), 16'h1); chk("start_e1", 16'(bus.start), 16'h1);
    chk("tick_e1", 16'(bus.tick), 16'h0);
    cyc(); chk("run_e2", 16'(bus.state), 16'h1); chk("tick_e2", 16'(bus.tick), 16'h0);
    cyc(); chk("run_e3", 16'(bus.state), 16'h1); chk("tick_e3", 16'(bus.tick), 16'h0);
    cyc(); chk("run_e4", 16'(bus.state), 16'h1); chk("tick_e4", 16'(bus.tick), 16'h1);
    cyc(); chk("run_e5", 16'(bus.state), 16'h1); chk("tick_e5", 16'(bus.tick), 16'h0);
    bus.start_key = 1'b0;
    cyc(); chk("tick_e6", 16'(bus.tick), 16'h0);
    cyc(); chk("tick_e7", 16'(bus.tick), 16'h0);
    cyc(); chk("tick_e8", 16'(bus.tick), 16'h1);

    pulse(2'd1);

    // align to a tick, then pause with count at 1
    n = 0;
    while (!bus.tick && n < 8) begin cyc(); n++; end
    chk("sync_tick", 16'(bus.tick), 16'h1);
    cyc();
    bus.start_key = 1'b1;
    bus.flap_key  = 1'b1;
    cyc();
    chk("pause_state", 16'(bus.state), 16'h2);
    chk("pause_start", 16'(bus.start), 16'h0);
    chk("pause_up",    16'(bus.up),    16'h0);
    bus.pipe_pass = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("pause_hold",  16'(bus.state), 16'h2);
      chk("pause_tick",  16'(bus.tick),  16'h0);
      chk("pause_up_f",  16'(bus.up),    16'h0);
      chk("pause_score", 16'(bus.score), 16'h1);
    end
    bus.pipe_pass = 1'b0;
    bus.start_key = 1'b0;
    cyc(); chk("pause_rel", 16'(bus.state), 16'h2);
    bus.start_key = 1'b1;
    cyc();
    chk("resume_state", 16'(bus.state), 16'h1);
    chk("resume_up",    16'(bus.up),    16'h1);
    chk("resume_t0",    16'(bus.tick),  16'h0);
    cyc(); chk("resume_t1", 16'(bus.tick), 16'h0);
    cyc(); chk("resume_t2", 16'(bus.tick), 16'h1);
    bus.flap_key  = 1'b0;
    bus.start_key = 1'b0;

    pulse(2'd2);
    pulse(2'd3);
    pulse(2'd3);
    pulse(2'd3);

    // fly off the top -> DEAD, then two ticks back to IDLE
    bus.bird_row = 16'h0000;
    cyc();
    chk("top_dead", 16'(bus.state), 16'h3);
    chk("top_die",  16'(bus.die),   16'h1);
    chk("top_start", 16'(bus.start), 16'h0);
    bus.bird_row = 16'h0100;
    ticks = 0;
    if (bus.tick) ticks++;
    bus.start_key = 1'b1;
    cyc();
    chk("top_die_low", 16'(bus.die),   16'h0);
    chk("dead_ignore", 16'(bus.state), 16'h3);
    n = 0;
    while (bus.state == 2'b11 && n < 40) begin
      if (bus.tick) ticks++;
      cyc();
      n++;
    end
    chk("dead_exit",   16'(bus.state), 16'h0);
    chk("dead_ticks",  16'(ticks),     16'd2);
    chk("idle_score",  16'(bus.score), 16'h3);
    bus.start_key = 1'b0;
    cyc();
    chk("idle_stay", 16'(bus.state), 16'h0);

    // game 2: score clears, up latency, hit beats pipe_pass
    bus.start_key = 1'b1;
    cyc();
    chk("g2_run",   16'(bus.state), 16'h1);
    chk("g2_score", 16'(bus.score), 16'h0);
    bus.start_key = 1'b0;
    bus.flap_key  = 1'b1;
    cyc(); chk("g2_up1", 16'(bus.up), 16'h1);
    bus.flap_key = 1'b0;
    cyc(); chk("g2_up0", 16'(bus.up), 16'h0);
    pulse(2'd1);
    bus.pipe_col  = 16'h0100;
    bus.pipe_pass = 1'b1;
    cyc();
    chk("hit_state", 16'(bus.state), 16'h3);
    chk("hit_die",   16'(bus.die),   16'h1);
    chk("hit_score", 16'(bus.score), 16'h1);
    bus.pipe_col  = 16'h0000;
    bus.pipe_pass = 1'b0;
    cyc();
    chk("hit_die_low", 16'(bus.die), 16'h0);
    reset = 1'b1;
    cyc();
    chk("rdead_state", 16'(bus.state), 16'h0);
    chk("rdead_score", 16'(bus.score), 16'h0);
    chk("rdead_die",   16'(bus.die),   16'h0);
    reset = 1'b0;
    cyc();

    // game 3: reset while paused
    bus.start_key = 1'b1;
    cyc(); chk("g3_run", 16'(bus.state), 16'h1);
    bus.start_key = 1'b0;
    cyc();
    pulse(2'd1);
    bus.flap_key  = 1'b1;
    bus.start_key = 1'b1;
    cyc(); chk("g3_pause", 16'(bus.state), 16'h2);
    reset = 1'b1;
    bus.start_key = 1'b0;
    cyc();
    chk("rpause_state", 16'(bus.state), 16'h0);
    chk("rpause_score", 16'(bus.score), 16'h0);
    chk("rpause_start", 16'(bus.start), 16'h0);
    chk("rpause_up",    16'(bus.up),    16'h0);
    chk("rpause_tick",  16'(bus.tick),  16'h0);
    reset = 1'b0;
    bus.flap_key = 1'b0;
    cyc();
    chk("final_idle", 16'(bus.state), 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
